// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control beside the IF/ID and ID/EX registers.
// Tracks EX/MEM/WB shadow state, raises load-use stalls, branch flushes,
// operand forwarding selects and the HALT drain sequence.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned DRAIN    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          opCode,
  input  logic                idValid,
  input  logic [REG_BITS-1:0] rs1,
  input  logic [REG_BITS-1:0] rs2,
  input  logic [REG_BITS-1:0] rd,
  input  logic                regWrite,
  input  logic [1:0]          memRead,
  input  logic                brTaken,
  output logic                pcWrite,
  output logic                ifidWrite,
  output logic                ifidFlush,
  output logic                idexBubble,
  output logic [1:0]          fwdA,
  output logic [1:0]          fwdB,
`ifdef HAZARD_STATS_EN
  output logic [15:0]         stallCount,
  output logic [15:0]         flushCount,
`endif
  output logic                halted
);

  // Counter only has to hold DRAIN-1.
  localparam int unsigned CntW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e              stateQ, stateD;
  logic [CntW-1:0]     cntQ, cntD;

  logic                exRw, exLd;
  logic [REG_BITS-1:0] exRd, exRs1, exRs2;
  logic                memRw, wbRw;
  logic [REG_BITS-1:0] memRd, wbRd;

  logic                loadUse;

  assign loadUse = idValid && exLd && ((exRd == rs1) || (exRd == rs2));

  // Arbitration: pipeline enables and next FSM state from current state and ID/EX hazards.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    halted     = 1'b0;
    unique case (stateQ)
      StRun: begin
        if (brTaken) begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
        end else if (loadUse) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
        end else if (idValid && (opCode == 4'b1111)) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
          if (DRAIN == 0) begin
            stateD = StHalted;
          end else begin
            stateD = StDrain;
            cntD   = CntW'(DRAIN - 1);
          end
        end
      end
      StDrain: begin
        // Nothing older than HALT can still be resolving a branch here.
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        if (cntQ == '0) begin
          stateD = StHalted;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      StHalted: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        halted     = 1'b1;
      end
      default: stateD = StRun;
    endcase
    if (rst) begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      ifidFlush  = 1'b0;
      idexBubble = 1'b0;
      halted     = 1'b0;
    end
  end

  // Forwarding selects: EX/MEM result beats the older MEM/WB result.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (!rst) begin
      if (memRw && (memRd == exRs1)) begin
        fwdA = 2'b01;
      end else if (wbRw && (wbRd == exRs1)) begin
        fwdA = 2'b10;
      end
      if (memRw && (memRd == exRs2)) begin
        fwdB = 2'b01;
      end else if (wbRw && (wbRd == exRs2)) begin
        fwdB = 2'b10;
      end
    end
  end

  // FSM, drain counter and EX/MEM/WB shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StRun;
      cntQ   <= '0;
      exRw   <= 1'b0;
      exLd   <= 1'b0;
      exRd   <= '0;
      exRs1  <= '0;
      exRs2  <= '0;
      memRw  <= 1'b0;
      memRd  <= '0;
      wbRw   <= 1'b0;
      wbRd   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      memRw  <= exRw;
      memRd  <= exRd;
      wbRw   <= memRw;
      wbRd   <= memRd;
      // Register fields always follow ID; a bubble only kills the control bits.
      exRd   <= rd;
      exRs1  <= rs1;
      exRs2  <= rs2;
      if (idValid && !idexBubble) begin
        exRw <= regWrite;
        exLd <= (memRead != 2'b00);
      end else begin
        exRw <= 1'b0;
        exLd <= 1'b0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating counts of honoured load-use stalls and taken-branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if ((stateQ == StRun) && !brTaken && loadUse && (stallCount != 16'hFFFF)) begin
        stallCount <= stallCount + 16'd1;
      end
      if ((stateQ == StRun) && brTaken && (flushCount != 16'hFFFF)) begin
        flushCount <= flushCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, HALT/reset
// sequence, then randomized traffic against a stage-list reference model.
module tb_hazard_unit;

  localparam int unsigned RB = 4;
  localparam int unsigned DR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    opCode;
  logic          idValid;
  logic [RB-1:0] rs1, rs2, rd;
  logic          regWrite;
  logic [1:0]    memRead;
  logic          brTaken;
  logic          pcWrite, ifidWrite, ifidFlush, idexBubble, halted;
  logic [1:0]    fwdA, fwdB;
`ifdef HAZARD_STATS_EN
  logic [15:0]   stallCount, flushCount;
`endif

  hazard_unit #(.REG_BITS(RB), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .idValid(idValid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .regWrite(regWrite), .memRead(memRead),
    .brTaken(brTaken), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .ifidFlush(ifidFlush), .idexBubble(idexBubble), .fwdA(fwdA), .fwdB(fwdB),
`ifdef HAZARD_STATS_EN
    .stallCount(stallCount), .flushCount(flushCount),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] op, input logic v, input logic [RB-1:0] a,
                       input logic [RB-1:0] b, input logic [RB-1:0] d, input logic w,
                       input logic [1:0] m, input logic br);
    rst = r; opCode = op; idValid = v; rs1 = a; rs2 = b; rd = d;
    regWrite = w; memRead = m; brTaken = br;
  endtask

  // ctl packs {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}
  typedef struct {
    logic rst; logic [3:0] op; logic v; logic [RB-1:0] r1, r2, d; logic rw; logic [1:0] mr;
    logic br; logic [4:0] ctl; logic cf; logic [1:0] fa, fb;
  } vec_t;

  // Reference pipeline stage: an instruction (or bubble) and its register use.
  typedef struct { bit v; bit rw; bit ld; int rd; int rs1; int rs2; } stg_t;

  function automatic int refFwd(input stg_t mem, input stg_t wb, input int src);
    if (mem.rw && mem.rd == src) return 1;
    if (wb.rw && wb.rd == src) return 2;
    return 0;
  endfunction

  vec_t tbl[12];

  initial begin
    stg_t mEx, mMem, mWb, nb;
    bit mHalt;
    int mSince, mStall, mFlush;

    // Row order: rst op v rs1 rs2 rd rw mr br | ctl chkFwd fwdA fwdB
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd0, 2'd0};
    tbl[1]  = '{1'b0, 4'h2, 1'b1, 4'd1, 4'd1, 4'd3, 1'b1, 2'd1, 1'b0, 5'b11000, 1'b0, 2'd0, 2'd0};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'd3, 4'd0, 4'd4, 1'b1, 2'd0, 1'b0, 5'b00010, 1'b1, 2'd0, 2'd0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'd3, 4'd0, 4'd4, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b0, 2'd0, 2'd0};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 4'd1, 4'd1, 4'd5, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd2, 2'd0};
    tbl[5]  = '{1'b0, 4'h1, 1'b1, 4'd5, 4'd5, 4'd6, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd0, 2'd0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd1, 2'd1};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd0, 2'd0};
    tbl[8]  = '{1'b0, 4'h3, 1'b1, 4'd2, 4'd1, 4'd7, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b1, 2'd0, 2'd0};
    tbl[9]  = '{1'b0, 4'h2, 1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 2'd2, 1'b0, 5'b11000, 1'b1, 2'd1, 2'd0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 4'd0, 4'd9, 4'd1, 1'b1, 2'd0, 1'b1, 5'b11110, 1'b1, 2'd0, 2'd0};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 4'd0, 4'd9, 4'd1, 1'b1, 2'd0, 1'b0, 5'b11000, 1'b0, 2'd0, 2'd0};

    drive(1'b1, 4'h0, 1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);

    // Directed table: load-use, back-to-back ALU, double match, branch vs load-use.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].op, tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].d, tbl[i].rw,
            tbl[i].mr, tbl[i].br);
      #1;
      check($sformatf("vec%0d ctl", i), {pcWrite, ifidWrite, ifidFlush, idexBubble, halted},
            tbl[i].ctl);
      if (tbl[i].cf) begin
        check($sformatf("vec%0d fwdA", i), fwdA, tbl[i].fa);
        check($sformatf("vec%0d fwdB", i), fwdB, tbl[i].fb);
      end
    end

    // HALT, drain with an ignored branch, halted hold, then reset back to RUN.
    @(negedge clk);
    drive(1'b0, 4'hF, 1'b1, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    #1 check("halt ctl", {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, 5'b00010);
`ifdef HAZARD_STATS_EN
    check("tbl stallCount", stallCount, 1);
    check("tbl flushCount", flushCount, 1);
`endif
    for (int k = 1; k <= int'(DR); k++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, '0, '0, '0, 1'b0, 2'd0, k == 1);
      #1 check($sformatf("drain%0d ctl", k),
               {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, 5'b00010);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b1, '0, '0, '0, 1'b0, 2'd0, 1'b0);
      #1 check($sformatf("halted%0d ctl", k),
               {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, 5'b00011);
    end
`ifdef HAZARD_STATS_EN
    check("drain flushCount", flushCount, 1);
`endif
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    #1 check("rst ctl", {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, 5'b11000);
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, '0, '0, '0, 1'b0, 2'd0, 1'b0);
    #1 check("postrst ctl", {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, 5'b11000);

    // Randomized traffic against the stage-list model.
    nb = '{v: 0, rw: 0, ld: 0, rd: 0, rs1: 0, rs2: 0};
    mEx = nb; mMem = nb; mWb = nb;
    mHalt = 0; mSince = 0; mStall = 0; mFlush = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, v, w, br, lu, enter;
      logic [3:0] op;
      logic [RB-1:0] a, b, d;
      logic [1:0] m;
      logic [4:0] ctl;
      @(negedge clk);
      if (i == 0) r = 1'b1;
      else if (mHalt && mSince > int'(DR) + 2) r = ($urandom_range(0, 3) == 0);
      else r = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 7) != 0);
      op = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      a  = RB'($urandom_range(0, 3));
      b  = RB'($urandom_range(0, 3));
      d  = RB'($urandom_range(0, 3));
      w  = $urandom_range(0, 3) != 0;
      m  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      br = ($urandom_range(0, 7) == 0);
      drive(r, op, v, a, b, d, w, m, br);

      lu = v && mEx.ld && (mEx.rd == int'(a) || mEx.rd == int'(b));
      enter = 0;
      if (r) ctl = 5'b11000;
      else if (mHalt) ctl = {4'b0001, mSince > int'(DR)};
      else if (br) ctl = 5'b11110;
      else if (lu) ctl = 5'b00010;
      else if (v && op == 4'hF) begin ctl = 5'b00010; enter = 1; end
      else ctl = 5'b11000;

      #1;
      check($sformatf("rnd%0d ctl", i), {pcWrite, ifidWrite, ifidFlush, idexBubble, halted}, ctl);
      if (r) begin
        check($sformatf("rnd%0d fwd", i), {fwdA, fwdB}, 4'b0000);
      end else if (mEx.v) begin
        check($sformatf("rnd%0d fwdA", i), fwdA, refFwd(mMem, mWb, mEx.rs1));
        check($sformatf("rnd%0d fwdB", i), fwdB, refFwd(mMem, mWb, mEx.rs2));
      end
`ifdef HAZARD_STATS_EN
      check($sformatf("rnd%0d stallCount", i), stallCount, mStall);
      check($sformatf("rnd%0d flushCount", i), flushCount, mFlush);
`endif

      // Advance the model across the coming rising edge.
      if (r) begin
        mEx = nb; mMem = nb; mWb = nb;
        mHalt = 0; mSince = 0; mStall = 0; mFlush = 0;
      end else begin
        if (!mHalt && br && mFlush < 65535) mFlush++;
        if (!mHalt && !br && lu && mStall < 65535) mStall++;
        if (mHalt) mSince++;
        else if (enter) begin mHalt = 1; mSince = 1; end
        mWb = mMem;
        mMem = mEx;
        if (v && !ctl[1]) mEx = '{v: 1, rw: w, ld: (m != 0), rd: int'(d), rs1: int'(a), rs2: int'(b)};
        else mEx = nb;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer end of the decode control bundle: takes per-instruction control outputs plus register fields in ID and enforces them across the pipeline.
- Tracks ID/EX, EX/MEM and MEM/WB shadow state (regWrite, load, rd, rs).
- Generates load-use stalls, branch/jump flushes, forwarding selects and the halt drain sequence.
- Sits beside the IF/ID and ID/EX pipeline registers; drives their write/flush enables and the PC write enable.

Parameters:
- REG_BITS, 4, width of register specifier fields (16 GPRs).
- DRAIN, 3, cycles waited after HALT leaves ID before halted asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- opCode  input  4  opcode of the instruction in ID.
- idValid  input  1  ID holds a real (non-bubble) instruction.
- rs1  input  REG_BITS  first source register in ID.
- rs2  input  REG_BITS  second source register in ID.
- rd  input  REG_BITS  destination register in ID.
- regWrite  input  1  decode control: instruction writes rd.
- memRead  input  2  decode control: nonzero means load (1=word, 2=byte unsigned).
- brTaken  input  1  branch/jump in EX resolved taken this cycle.
- pcWrite  output  1  PC update enable.
- ifidWrite  output  1  IF/ID register write enable.
- ifidFlush  output  1  clear IF/ID to bubble.
- idexBubble  output  1  load ID/EX with zero control (bubble).
- fwdA  output  2  EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwdB  output  2  same for operand B.
- halted  output  1  pipeline stopped after HALT drained.

Behaviour:
- FSM states RUN, DRAIN, HALTED; registered in a single always block; reset state RUN.
- Shadow regs:
  - EX stage: ex_rw, ex_ld, ex_rd, ex_rs1, ex_rs2.
  - MEM stage: mem_rw, mem_rd.
  - WB stage: wb_rw, wb_rd.
  - All clear to 0 on rst.
- Each clock: mem<-ex, wb<-mem.
  - ex<-ID fields when idValid && !idexBubble; otherwise ex_rw=ex_ld=0.
  - ex_ld = (memRead != 0).
- Outputs are combinational from state, shadow regs and inputs (zero-latency).
- During rst high, outputs are forced to: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, fwdA=fwdB=00, halted=0.
- loadUse = idValid && ex_ld && (ex_rd==rs1 || ex_rd==rs2).
- RUN priority, highest first:
  1. brTaken: ifidFlush=1, idexBubble=1, pcWrite=1, ifidWrite=1; loadUse and HALT ignored; stay RUN.
  2. loadUse: pcWrite=0, ifidWrite=0, idexBubble=1; exactly one stall cycle per dependency (after the bubble ex_ld=0, so the stall releases).
  3. idValid && opCode==4'b1111: pcWrite=0, ifidWrite=0, idexBubble=1.
     - Counter loads DRAIN-1; next state DRAIN.
     - With DRAIN=0, go directly to HALTED.
  4. else: pcWrite=1, ifidWrite=1, no flush/bubble.
- DRAIN: pcWrite=0, ifidWrite=0, idexBubble=1, ifidFlush=0.
  - brTaken is ignored; an older branch cannot be in EX at this point.
  - Counter decrements each cycle; at 0 the next state is HALTED.
- HALTED: same enables as DRAIN, halted=1. Exits only via rst.
- Forwarding, same rule for both operands:
  - fwdA=01 if mem_rw && mem_rd==ex_rs1.
  - else fwdA=10 if wb_rw && wb_rd==ex_rs1.
  - else 00.
  - fwdB uses ex_rs2 in the same way.
  - EX/MEM has priority over MEM/WB when both match.
  - No register is hardwired; R0 forwards like any other.
- Reset mid-DRAIN or in HALTED: next cycle is RUN with shadow regs cleared.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stallCount[15:0] and flushCount[15:0].
  - Cleared on rst.
  - stallCount increments each cycle loadUse wins arbitration in RUN.
  - flushCount increments each cycle brTaken is honoured.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Load-use: LOAD r3 in EX, ADD reading r3 in ID -> one cycle of pcWrite=0/ifidWrite=0/idexBubble=1; next cycle fwdA=10 with wb_rd=3.
- Back-to-back ALU: ADD r5 then SUB r5,r5 -> no stall; fwdA=fwdB=01 in the SUB EX cycle.
- Double match: r2 written by both EX/MEM and MEM/WB -> fwdA=01, not 10.
- Branch vs load-use: brTaken=1 in the same cycle loadUse is true -> ifidFlush=1, idexBubble=1, pcWrite=1; no stall cycle follows.
- Halt: opCode=4'b1111 in ID with DRAIN=3 -> pcWrite=0 from that cycle; halted=1 on the 4th cycle after; remains until rst; rst -> RUN, halted=0.
- Stats (HAZARD_STATS_EN): 2 load-use stalls + 3 taken branches -> stallCount=2, flushCount=3.
